is_calc_fsm: RTL

- Parametrised command engine for the UART calculator; replaces the fixed-width single-operation controller.
- Receives an N_DIG-digit hex operand terminated by CR LF and combines it with a persistent accumulator using a run-time selectable operation.
- Returns the result as ASCII hex plus CR LF, or streams an error message from the message ROM.
- Sits between the UART RX/TX cores and the message ROM.

---
 rtl/is_calc_fsm_pkg.sv | 48 ++++
 rtl/is_calc_fsm_hex_codec.sv | 30 +++
 rtl/is_calc_fsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/is_calc_fsm_pkg.sv
// Shared types and constants for the UART calculator engine: FSM states, operations,
// ASCII control bytes and the message ROM layout (inclusive start/end per message).
package is_pkg_uart_controller;

  typedef enum logic [2:0] {
    S_DIG, S_CR, S_LF, S_CALC, S_RES, S_EOL, S_EREQ, S_ESEND
  } state_f;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_AND = 2'b11
  } op_mode;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] ESC = 8'h1B;

  localparam int START_EADDR_OP_F  = 0;
  localparam int END_EADDR_OP_F    = 12;
  localparam int START_EADDR_PR    = 13;
  localparam int END_EADDR_PR      = 22;
  localparam int START_EADDR_FR    = 23;
  localparam int END_EADDR_FR      = 31;
  localparam int START_EADDR_FR_PR = 32;
  localparam int END_EADDR_FR_PR   = 47;

  // sel = {frame_err, parity_err}
  function automatic int msg_start(input logic [1:0] sel);
    case (sel)
      2'b00:   return START_EADDR_OP_F;
      2'b01:   return START_EADDR_PR;
      2'b10:   return START_EADDR_FR;
      default: return START_EADDR_FR_PR;
    endcase
  endfunction

  function automatic int msg_end(input logic [1:0] sel);
    case (sel)
      2'b00:   return END_EADDR_OP_F;
      2'b01:   return END_EADDR_PR;
      2'b10:   return END_EADDR_FR;
      default: return END_EADDR_FR_PR;
    endcase
  endfunction

endpackage

// File: rtl/is_calc_fsm_hex_codec.sv
// Combinational hex codec: ASCII char to nibble (with valid flag) and nibble to
// uppercase ASCII. Both directions are independent; no state, zero latency.
module is_hex_codec #(
  parameter int W = 8
) (
  input  logic [W-1:0] asc_in,
  output logic [3:0]   nib_out,
  output logic         nib_ok,
  input  logic [3:0]   nib_in,
  output logic [W-1:0] asc_out
);

  always_comb begin
    nib_out = 4'h0;
    nib_ok  = 1'b0;
    if (asc_in >= W'(8'h30) && asc_in <= W'(8'h39)) begin
      nib_out = 4'(asc_in - W'(8'h30));
      nib_ok  = 1'b1;
    end else if (asc_in >= W'(8'h41) && asc_in <= W'(8'h46)) begin
      nib_out = 4'(asc_in - W'(8'h37));
      nib_ok  = 1'b1;
    end else if (asc_in >= W'(8'h61) && asc_in <= W'(8'h66)) begin
      nib_out = 4'(asc_in - W'(8'h57));
      nib_ok  = 1'b1;
    end
  end

  assign asc_out = (nib_in < 4'd10) ? W'(8'h30) + W'(nib_in) : W'(8'h37) + W'(nib_in);

endmodule

// File: rtl/is_calc_fsm.sv
// Command engine: collects an N_DIG-digit hex operand + CR LF, folds it into the accumulator
// with the selected op, and replies with the result in hex or a ROM error message.
module is_calc_fsm
  import is_pkg_uart_controller::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_DIG     = 4,
  parameter int MEM_WIDTH = 6,
  parameter int ACC_INIT  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           op_mode_i,
  input  logic                 rx_valid_i,
  input  logic [DATA_W+1:0]    rx_data_i,
  output logic                 tx_valid_o,
  output logic [DATA_W-1:0]    tx_data_o,
  input  logic                 tx_rdy_i,
  output logic [MEM_WIDTH-1:0] addr_o,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 busy_o,
  output logic [4*N_DIG-1:0]   acc_o,
  output logic [7:0]           err_cnt_o
);

  localparam int ACC_W = 4 * N_DIG;
  localparam logic [ACC_W-1:0] ACC_RST = ACC_W'(ACC_INIT);

  state_f                 state, state_n;
  logic [3:0]             cnt, cnt_n, idx, idx_n;
  logic [ACC_W-1:0]       opnd, opnd_n, acc, acc_n;
  logic [7:0]             err_cnt, err_n;
  logic [MEM_WIDTH-1:0]   addr, addr_n, eend, eend_n;
  logic                   rej;

  logic                   fe, pe;
  logic [DATA_W-1:0]      rx_byte;
  logic [3:0]             rx_nib, tx_nib;
  logic                   rx_hex;
  logic [DATA_W-1:0]      tx_asc;
  logic [DATA_W-1:0]      dec_asc_unused;
  logic [3:0]             enc_nib_unused;
  logic                   enc_ok_unused;

  assign {fe, pe, rx_byte} = rx_data_i;
  assign tx_nib = 4'(acc >> (4 * (N_DIG - 1 - int'(idx))));

  is_hex_codec #(.W(DATA_W)) u_dec (
    .asc_in (rx_byte),
    .nib_out(rx_nib),
    .nib_ok (rx_hex),
    .nib_in (4'h0),
    .asc_out(dec_asc_unused)
  );

  is_hex_codec #(.W(DATA_W)) u_enc (
    .asc_in ('0),
    .nib_out(enc_nib_unused),
    .nib_ok (enc_ok_unused),
    .nib_in (tx_nib),
    .asc_out(tx_asc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_DIG;
      cnt     <= '0;
      idx     <= '0;
      opnd    <= '0;
      acc     <= ACC_RST;
      err_cnt <= '0;
      addr    <= '0;
      eend    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      opnd    <= opnd_n;
      acc     <= acc_n;
      err_cnt <= err_n;
      addr    <= addr_n;
      eend    <= eend_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    opnd_n     = opnd;
    acc_n      = acc;
    err_n      = err_cnt;
    addr_n     = addr;
    eend_n     = eend;
    rej        = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;

    case (state)
      S_DIG, S_CR, S_LF: begin
        // error bits and ESC are decided before any digit/terminator handling
        if (rx_valid_i) begin
          if (fe || pe) begin
            rej = 1'b1;
          end else if (rx_byte == DATA_W'(ESC)) begin
            acc_n   = ACC_RST;
            cnt_n   = '0;
            state_n = S_DIG;
          end else if (state == S_DIG && rx_hex) begin
            opnd_n = (opnd << 4) | ACC_W'(rx_nib);
            if (cnt == 4'(N_DIG - 1)) begin
              cnt_n   = '0;
              state_n = S_CR;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else if (state == S_CR && rx_byte == DATA_W'(CR)) begin
            state_n = S_LF;
          end else if (state == S_LF && rx_byte == DATA_W'(LF)) begin
            state_n = S_CALC;
          end else begin
            rej = 1'b1;
          end
        end
        if (rej) begin
          addr_n  = MEM_WIDTH'(msg_start({fe, pe}));
          eend_n  = MEM_WIDTH'(msg_end({fe, pe}));
          err_n   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
          cnt_n   = '0;
          state_n = S_EREQ;
        end
      end

      S_CALC: begin
        case (op_mode'(op_mode_i))
          OP_ADD:  acc_n = acc + opnd;
          OP_SUB:  acc_n = acc - opnd;
          OP_XOR:  acc_n = acc ^ opnd;
          default: acc_n = acc & opnd;
        endcase
        idx_n   = '0;
        state_n = S_RES;
      end

      S_RES: begin
        tx_valid_o = 1'b1;
        tx_data_o  = tx_asc;
        if (tx_rdy_i) begin
          if (idx == 4'(N_DIG - 1)) begin
            idx_n   = '0;
            state_n = S_EOL;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end

      S_EOL: begin
        tx_valid_o = 1'b1;
        tx_data_o  = idx[0] ? DATA_W'(LF) : DATA_W'(CR);
        if (tx_rdy_i) begin
          idx_n = idx[0] ? 4'd0 : 4'd1;
          if (idx[0]) state_n = S_DIG;
        end
      end

      S_EREQ: state_n = S_ESEND;

      S_ESEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = data_i;
        if (tx_rdy_i) begin
          if (addr == eend) begin
            state_n = S_DIG;
          end else begin
            addr_n  = addr + MEM_WIDTH'(1);
            state_n = S_EREQ;
          end
        end
      end

      default: state_n = S_DIG;
    endcase
  end

  assign busy_o    = (state == S_RES) || (state == S_EOL) || (state == S_EREQ) || (state == S_ESEND);
  assign addr_o    = addr;
  assign acc_o     = acc;
  assign err_cnt_o = err_cnt;

endmodule
